// File: rtl/rr8_tree_pipelined_arbiter.sv
// rr8_tree_pipelined_arbiter: 8-way round-robin arbiter built as a tree of 2:1 nodes, two register stages.
// Stage 1 registers the four leaf decisions, and stage 2 resolves the mid and root nodes into a one-hot grant.
module rr8_tree_pipelined_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt
);
    logic [3:0] leaf_ptr;
    logic [3:0] leaf_valid_d;
    logic [3:0] leaf_sel_d;
    logic [3:0] leaf_valid;
    logic [3:0] leaf_sel;
    logic [1:0] mid_ptr;
    logic [1:0] mid_valid;
    logic [1:0] mid_sel;
    logic       root_ptr;
    logic       root_valid;
    logic       root_sel;
    logic [1:0] gnt_leaf;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_d;

    // A set pointer favours the right (upper) side. Select 1 means the right side was chosen.
    function automatic logic pick(input logic l, input logic r, input logic p);
        return r & (~l | p);
    endfunction

    always_comb begin
        leaf_valid_d = '0;
        leaf_sel_d   = '0;
        for (int i = 0; i < 4; i++) begin
            leaf_valid_d[i] = req[2*i] | req[2*i+1];
            leaf_sel_d[i]   = pick(req[2*i], req[2*i+1], leaf_ptr[i]);
        end
    end

    always_comb begin
        mid_valid  = '0;
        mid_sel    = '0;
        for (int j = 0; j < 2; j++) begin
            mid_valid[j] = leaf_valid[2*j] | leaf_valid[2*j+1];
            mid_sel[j]   = pick(leaf_valid[2*j], leaf_valid[2*j+1], mid_ptr[j]);
        end
        root_valid = |mid_valid;
        root_sel   = pick(mid_valid[0], mid_valid[1], root_ptr);
        gnt_leaf   = {root_sel, mid_sel[root_sel]};
        gnt_idx    = {gnt_leaf, leaf_sel[gnt_leaf]};
        gnt_d      = root_valid ? 8'(1) << gnt_idx : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leaf_valid <= '0;
            leaf_sel   <= '0;
        end else begin
            leaf_valid <= leaf_valid_d;
            leaf_sel   <= leaf_sel_d;
        end
    end

    // Only nodes on the granted path flip to favour the opposite side.
    // Stage 1 sampling at this same edge still sees the old leaf pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            root_ptr <= 1'b0;
            mid_ptr  <= '0;
            leaf_ptr <= '0;
        end else begin
            gnt <= gnt_d;
            if (root_valid) begin
                root_ptr           <= ~root_sel;
                mid_ptr[root_sel]  <= ~mid_sel[root_sel];
                leaf_ptr[gnt_leaf] <= ~leaf_sel[gnt_leaf];
            end
        end
    end
endmodule

// File: tb/tb_rr8_tree_pipelined_arbiter.sv
// tb_rr8_tree_pipelined_arbiter: directed vector table plus random and mid-stream reset sequences.
// Each row drives req after a falling edge and checks gnt one falling edge later.
module tb_rr8_tree_pipelined_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       do_rst;
        logic [7:0] req;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    rr8_tree_pipelined_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: gnt=%h expected %h", name, act, exp);
        end
    endtask

    // Assert reset partway through the low clock phase, check it acts without a clock, then release.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 check("reset_async", gnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic [7:0] e);
        vec_t v;
        v.do_rst = r;
        v.req    = q;
        v.exp    = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] prev;
        logic [7:0] cur;
        // Steady all-ones after reset.
        add(1, 8'hFF, 8'h00);
        add(0, 8'hFF, 8'h01); add(0, 8'hFF, 8'h10); add(0, 8'hFF, 8'h04); add(0, 8'hFF, 8'h40);
        add(0, 8'hFF, 8'h02); add(0, 8'hFF, 8'h20); add(0, 8'hFF, 8'h08); add(0, 8'hFF, 8'h80);
        add(0, 8'hFF, 8'h01); add(0, 8'hFF, 8'h10); add(0, 8'hFF, 8'h04);
        // Mid-stream reset with req still 8'hFF: the sequence restarts at 01.
        add(1, 8'hFF, 8'h00);
        add(0, 8'hFF, 8'h01); add(0, 8'hFF, 8'h10); add(0, 8'hFF, 8'h04);
        // Walking one, then idle.
        add(1, 8'h01, 8'h00);
        add(0, 8'h02, 8'h01); add(0, 8'h04, 8'h02); add(0, 8'h08, 8'h04); add(0, 8'h10, 8'h08);
        add(0, 8'h20, 8'h10); add(0, 8'h40, 8'h20); add(0, 8'h80, 8'h40); add(0, 8'h00, 8'h80);
        add(0, 8'h00, 8'h00);
        // Odd-only and even-only request sets.
        add(1, 8'hAA, 8'h00);
        add(0, 8'hAA, 8'h02); add(0, 8'hAA, 8'h20); add(0, 8'hAA, 8'h08); add(0, 8'hAA, 8'h80);
        add(0, 8'hAA, 8'h02);
        add(1, 8'h55, 8'h00);
        add(0, 8'h55, 8'h01); add(0, 8'h55, 8'h10); add(0, 8'h55, 8'h04); add(0, 8'h55, 8'h40);
        add(0, 8'h55, 8'h01);

        #3 check("reset_initial", gnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) pulse_reset();
            req = vecs[i].req;
            @(negedge clk);
            check($sformatf("vec%0d", i), gnt, vecs[i].exp);
        end

        // Random traffic: grant is one-hot or zero and backed by the previous request.
        pulse_reset();
        prev = 8'h00;
        for (int i = 0; i < 40; i++) begin
            cur = (i % 7 == 3) ? 8'h00 : 8'($urandom);
            req = cur;
            @(negedge clk);
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("FAIL rand_onehot%0d: gnt=%h expected one-hot or zero", i, gnt);
            end
            checks++;
            if ((gnt & ~prev) != 8'h00) begin
                errors++;
                $display("FAIL rand_backed%0d: gnt=%h expected a subset of req %h", i, gnt, prev);
            end
            checks++;
            if ((gnt == 8'h00) != (prev == 8'h00)) begin
                errors++;
                $display("FAIL rand_idle%0d: gnt=%h for req %h", i, gnt, prev);
            end
            prev = cur;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
